// File: rtl/rf_pkg.sv
// Shared register-file constants and types, imported by the operand-fetch
// stage, its scoreboard and the register file itself.
package rf_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0]   rf_addr_t;
    typedef logic [DATA_W-1:0]   rf_data_t;
    typedef logic [NUM_REGS-1:0] rf_busy_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register marks an in-flight destination
// write. One set port, two clear ports (writeback, flush), three lookups.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     i_set_en,
    input  rf_addr_t i_set_addr,
    input  logic     i_clr_wb_en,
    input  rf_addr_t i_clr_wb_addr,
    input  logic     i_clr_fl_en,
    input  rf_addr_t i_clr_fl_addr,
    input  rf_addr_t i_q0_addr,
    input  rf_addr_t i_q1_addr,
    input  rf_addr_t i_q2_addr,
    output logic     o_q0_busy,
    output logic     o_q1_busy,
    output logic     o_q2_busy,
    output rf_busy_t o_busy
);

    rf_busy_t r_busy;
    rf_busy_t w_set_mask;
    rf_busy_t w_clr_mask;
    rf_busy_t w_busy_nxt;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en)
            w_set_mask[i_set_addr] = 1'b1;
        if (i_clr_wb_en)
            w_clr_mask[i_clr_wb_addr] = 1'b1;
        if (i_clr_fl_en)
            w_clr_mask[i_clr_fl_addr] = 1'b1;
        // Set is applied after the clears so a new writer keeps its register busy.
        w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign o_q0_busy = r_busy[i_q0_addr];
    assign o_q1_busy = r_busy[i_q1_addr];
    assign o_q2_busy = r_busy[i_q2_addr];
    assign o_busy    = r_busy;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: drives register-file reads, bypasses same-cycle
// writeback data, stalls RAW/WAW hazards and registers operands for execute.
module operand_fetch
    import rf_pkg::*;
#(
    parameter int CTL_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  rf_addr_t         in_rs0,
    input  rf_addr_t         in_rs1,
    input  rf_addr_t         in_rd,
    input  logic             in_use_rs0,
    input  logic             in_use_rs1,
    input  logic             in_wr_rd,
    input  logic [CTL_W-1:0] in_ctl,
    output logic [1:0]       rf_read_en,
    output rf_addr_t         rf_raddr_0,
    output rf_addr_t         rf_raddr_1,
    input  rf_data_t         rf_rdata_0,
    input  rf_data_t         rf_rdata_1,
    input  logic             wb_valid,
    input  rf_addr_t         wb_addr,
    input  rf_data_t         wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output rf_data_t         out_op0,
    output rf_data_t         out_op1,
    output rf_addr_t         out_rd,
    output logic             out_wr_rd,
    output logic [CTL_W-1:0] out_ctl,
    output rf_busy_t         busy
);

    logic             w_byp0;
    logic             w_byp1;
    logic             w_byp_rd;
    logic             w_busy0;
    logic             w_busy1;
    logic             w_busy_rd;
    logic             w_hazard;
    logic             w_issue;
    rf_data_t         w_op0;
    rf_data_t         w_op1;

    logic             r_vld_p1;
    rf_data_t         r_op0_p1;
    rf_data_t         r_op1_p1;
    rf_addr_t         r_rd_p1;
    logic             r_wr_rd_p1;
    logic [CTL_W-1:0] r_ctl_p1;

    assign rf_raddr_0 = in_rs0;
    assign rf_raddr_1 = in_rs1;
    assign rf_read_en = {in_valid & in_use_rs1, in_valid & in_use_rs0};

    // The writeback lands in the register file only at the next edge, so its
    // data is forwarded here and also resolves the matching busy bit early.
    assign w_byp0   = wb_valid && (wb_addr == in_rs0);
    assign w_byp1   = wb_valid && (wb_addr == in_rs1);
    assign w_byp_rd = wb_valid && (wb_addr == in_rd);

    always_comb begin
        w_op0 = '0;
        w_op1 = '0;
        if (in_use_rs0)
            w_op0 = w_byp0 ? wb_data : rf_rdata_0;
        if (in_use_rs1)
            w_op1 = w_byp1 ? wb_data : rf_rdata_1;
    end

    assign w_hazard = (in_use_rs0 & w_busy0   & ~w_byp0)
                    | (in_use_rs1 & w_busy1   & ~w_byp1)
                    | (in_wr_rd   & w_busy_rd & ~w_byp_rd);

    assign in_ready = (~r_vld_p1 | out_ready) & ~flush & ~w_hazard;
    assign w_issue  = in_valid & in_ready;

    rf_scoreboard u_scoreboard (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_set_en      (w_issue & in_wr_rd),
        .i_set_addr    (in_rd),
        .i_clr_wb_en   (wb_valid),
        .i_clr_wb_addr (wb_addr),
        .i_clr_fl_en   (flush & r_vld_p1 & r_wr_rd_p1),
        .i_clr_fl_addr (r_rd_p1),
        .i_q0_addr     (in_rs0),
        .i_q1_addr     (in_rs1),
        .i_q2_addr     (in_rd),
        .o_q0_busy     (w_busy0),
        .o_q1_busy     (w_busy1),
        .o_q2_busy     (w_busy_rd),
        .o_busy        (busy)
    );

    // Stage p1: output register toward execute.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p1   <= 1'b0;
            r_op0_p1   <= '0;
            r_op1_p1   <= '0;
            r_rd_p1    <= '0;
            r_wr_rd_p1 <= 1'b0;
            r_ctl_p1   <= '0;
        end else if (w_issue) begin
            r_vld_p1   <= 1'b1;
            r_op0_p1   <= w_op0;
            r_op1_p1   <= w_op1;
            r_rd_p1    <= in_rd;
            r_wr_rd_p1 <= in_wr_rd;
            r_ctl_p1   <= in_ctl;
        end else if (flush || (r_vld_p1 && out_ready)) begin
            r_vld_p1   <= 1'b0;
        end
    end

    assign out_valid = r_vld_p1;
    assign out_op0   = r_op0_p1;
    assign out_op1   = r_op1_p1;
    assign out_rd    = r_rd_p1;
    assign out_wr_rd = r_wr_rd_p1;
    assign out_ctl   = r_ctl_p1;

endmodule
